hazard_ctrl: RTL and testbench

- Pipeline hazard controller that consumes the execute-stage condition results (`PCSrcEout`, `BranchTakenE`) and the register-write intent of every stage.
- Produces the forwarding selects and the stall/flush controls for fetch, decode and execute.
- Tracks in-flight PC-writing instructions through E/M/W in its own registers, so fetch is held until a PC write retires.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/hazard_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 94 +++++++++
 tb/tb_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master side is the pipeline; the slave side is hazard_ctrl.
interface hazard_if #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [REG_AW-1:0] WA3E, WA3M, WA3W;
  logic              RegWriteE, MemtoRegE, RegWriteM, RegWriteW;
  logic              PCSrcD, PCSrcEout, BranchTakenE;
  logic              cnt_clr;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, FlushD, FlushE;
  logic              PCSrcW;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteE, MemtoRegE, RegWriteM, RegWriteW,
           PCSrcD, PCSrcEout, BranchTakenE, cnt_clr,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           PCSrcW, stall_cnt, flush_cnt
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteE, MemtoRegE, RegWriteM, RegWriteW,
           PCSrcD, PCSrcEout, BranchTakenE, cnt_clr,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           PCSrcW, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, PC-write
// tracking through E/M/W, branch flush, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 4
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  bus
);

  // The highest register address is the PC, which is never forwarded.
  localparam logic [REG_AW-1:0] PC_ADDR = '1;

  logic             r_pc_e, r_pc_m, r_pc_w;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_ldr_stall, w_pend_f;
  logic w_stall_f, w_stall_d, w_flush_d, w_flush_e;
  logic w_flush_e_raw;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] ra,
                                         input logic              rw_m,
                                         input logic [REG_AW-1:0] wa_m,
                                         input logic              rw_w,
                                         input logic [REG_AW-1:0] wa_w);
    if (ra == PC_ADDR)             return 2'b00;
    else if (rw_m && (wa_m == ra)) return 2'b10;
    else if (rw_w && (wa_w == ra)) return 2'b01;
    else                           return 2'b00;
  endfunction

  assign w_ldr_stall = bus.MemtoRegE & bus.RegWriteE &
                       ((bus.WA3E == bus.RA1D) | (bus.WA3E == bus.RA2D)) &
                       ~bus.BranchTakenE;
  assign w_pend_f      = bus.PCSrcD | r_pc_e | r_pc_m;
  assign w_flush_e_raw = w_ldr_stall | bus.BranchTakenE;

  always_comb begin
    // NOTE: every output gets its reset-time value first, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    w_stall_f     = 1'b0;
    w_stall_d     = 1'b0;
    w_flush_d     = 1'b1;
    w_flush_e     = 1'b1;
    if (!reset) begin
      bus.ForwardAE = fwd_sel(bus.RA1E, bus.RegWriteM, bus.WA3M,
                              bus.RegWriteW, bus.WA3W);
      bus.ForwardBE = fwd_sel(bus.RA2E, bus.RegWriteM, bus.WA3M,
                              bus.RegWriteW, bus.WA3W);
      // A taken branch releases fetch so the target is loaded.
      w_stall_f = ~bus.BranchTakenE & (w_ldr_stall | w_pend_f);
      w_stall_d = w_ldr_stall;
      w_flush_d = w_pend_f | r_pc_w | bus.BranchTakenE;
      w_flush_e = w_flush_e_raw;
    end
  end

  assign bus.StallF    = w_stall_f;
  assign bus.StallD    = w_stall_d;
  assign bus.FlushD    = w_flush_d;
  assign bus.FlushE    = w_flush_e;
  assign bus.PCSrcW    = r_pc_w;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_e <= 1'b0;
      r_pc_m <= 1'b0;
      r_pc_w <= 1'b0;
    end else begin
      r_pc_e <= bus.PCSrcD & ~w_flush_e_raw;
      r_pc_m <= bus.PCSrcEout & ~bus.BranchTakenE;
      r_pc_w <= r_pc_m;
    end
  end

  // Counters saturate at all-ones; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_e && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a history-based model.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int REG_AW  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       reset, cnt_clr, pcsrc_d, pcsrc_e, br_e;
    logic       rw_e, m2r_e, rw_m, rw_w;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
  } stim_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_if #(.CNT_W(CNT_W), .REG_AW(REG_AW)) bus ();

  hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    reset            = s.reset;
    bus.cnt_clr      = s.cnt_clr;
    bus.PCSrcD       = s.pcsrc_d;
    bus.PCSrcEout    = s.pcsrc_e;
    bus.BranchTakenE = s.br_e;
    bus.RegWriteE    = s.rw_e;
    bus.MemtoRegE    = s.m2r_e;
    bus.RegWriteM    = s.rw_m;
    bus.RegWriteW    = s.rw_w;
    bus.RA1D = s.ra1d;  bus.RA2D = s.ra2d;
    bus.RA1E = s.ra1e;  bus.RA2E = s.ra2e;
    bus.WA3E = s.wa3e;  bus.WA3M = s.wa3m;  bus.WA3W = s.wa3w;
  endtask

  // Drive one cycle's inputs after the edge, then settle past the negedge.
  task automatic cycle(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    @(negedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t ldr_use();
    stim_t s = '0;
    s.m2r_e = 1'b1; s.rw_e = 1'b1; s.wa3e = 4'd2; s.ra2d = 4'd2; s.ra1d = 4'd5;
    return s;
  endfunction

  function automatic logic [3:0] rand_reg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  // ---------------- behavioural reference model ----------------
  // Outputs follow from the current inputs plus the two previous cycles of
  // input history: a PC write enters E one cycle after decode (unless E is
  // flushed), and retires in W two cycles after E reports it taken.
  stim_t h1, h2;
  int    exp_sc = 0, exp_fc = 0;

  function automatic int m_fwd(input stim_t c, input logic [3:0] ra);
    if (ra == 4'd15)                 return 0;
    if (c.rw_m && c.wa3m == ra)      return 2;
    if (c.rw_w && c.wa3w == ra)      return 1;
    return 0;
  endfunction

  function automatic bit m_ldr(input stim_t c);
    return c.m2r_e && c.rw_e && (c.wa3e == c.ra1d || c.wa3e == c.ra2d) && !c.br_e;
  endfunction

  function automatic stim_t sample();
    stim_t c;
    c.reset = reset;          c.cnt_clr = bus.cnt_clr;
    c.pcsrc_d = bus.PCSrcD;   c.pcsrc_e = bus.PCSrcEout; c.br_e = bus.BranchTakenE;
    c.rw_e = bus.RegWriteE;   c.m2r_e = bus.MemtoRegE;
    c.rw_m = bus.RegWriteM;   c.rw_w = bus.RegWriteW;
    c.ra1d = bus.RA1D; c.ra2d = bus.RA2D; c.ra1e = bus.RA1E; c.ra2e = bus.RA2E;
    c.wa3e = bus.WA3E; c.wa3m = bus.WA3M; c.wa3w = bus.WA3W;
    return c;
  endfunction

  initial begin
    h1 = '0; h1.reset = 1'b1;
    h2 = '0; h2.reset = 1'b1;
  end

  always @(negedge clk) begin
    stim_t c;
    bit in_e, in_m, in_w, ldr, pend, e_sf, e_sd, e_fd, e_fe;
    int e_fa, e_fb;
    c    = sample();
    in_e = !h1.reset && h1.pcsrc_d && !(m_ldr(h1) || h1.br_e);
    in_m = !h1.reset && h1.pcsrc_e && !h1.br_e;
    in_w = !h1.reset && !h2.reset && h2.pcsrc_e && !h2.br_e;
    ldr  = m_ldr(c);
    pend = c.pcsrc_d || in_e || in_m;
    if (c.reset) begin
      e_fa = 0; e_fb = 0; e_sf = 0; e_sd = 0; e_fd = 1; e_fe = 1;
    end else begin
      e_fa = m_fwd(c, c.ra1e);
      e_fb = m_fwd(c, c.ra2e);
      e_sf = !c.br_e && (ldr || pend);
      e_sd = ldr;
      e_fd = pend || in_w || c.br_e;
      e_fe = ldr || c.br_e;
    end
    check("m_ForwardAE", int'(bus.ForwardAE), e_fa);
    check("m_ForwardBE", int'(bus.ForwardBE), e_fb);
    check("m_StallF",    int'(bus.StallF),    int'(e_sf));
    check("m_StallD",    int'(bus.StallD),    int'(e_sd));
    check("m_FlushD",    int'(bus.FlushD),    int'(e_fd));
    check("m_FlushE",    int'(bus.FlushE),    int'(e_fe));
    check("m_PCSrcW",    int'(bus.PCSrcW),    int'(in_w));
    check("m_stall_cnt", int'(bus.stall_cnt), exp_sc);
    check("m_flush_cnt", int'(bus.flush_cnt), exp_fc);
    if (c.reset || c.cnt_clr) begin
      exp_sc = 0;
      exp_fc = 0;
    end else begin
      exp_sc = (exp_sc + int'(e_sf) > CNT_MAX) ? CNT_MAX : exp_sc + int'(e_sf);
      exp_fc = (exp_fc + int'(e_fe) > CNT_MAX) ? CNT_MAX : exp_fc + int'(e_fe);
    end
    h2 = h1;
    h1 = c;
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    apply(idle());
    reset = 1'b1;

    // Reset forces safe controls even with hazards present on the inputs.
    s = ldr_use(); s.reset = 1'b1; s.rw_m = 1'b1; s.wa3m = 4'd3; s.ra1e = 4'd3;
    s.pcsrc_d = 1'b1;
    repeat (3) cycle(s);
    check("rst_FlushD",    int'(bus.FlushD),    1);
    check("rst_FlushE",    int'(bus.FlushE),    1);
    check("rst_StallF",    int'(bus.StallF),    0);
    check("rst_StallD",    int'(bus.StallD),    0);
    check("rst_ForwardAE", int'(bus.ForwardAE), 0);
    check("rst_PCSrcW",    int'(bus.PCSrcW),    0);
    cycle(idle());
    check("rst_stall_cnt", int'(bus.stall_cnt), 0);
    check("rst_flush_cnt", int'(bus.flush_cnt), 0);

    // Forwarding priority.
    s = idle(); s.rw_m = 1; s.rw_w = 1; s.wa3m = 3; s.wa3w = 3; s.ra1e = 3; s.ra2e = 3;
    cycle(s);
    check("fwd_M_A", int'(bus.ForwardAE), 2);
    check("fwd_M_B", int'(bus.ForwardBE), 2);
    s.rw_m = 0;
    cycle(s);
    check("fwd_W_A", int'(bus.ForwardAE), 1);
    s.rw_m = 1; s.wa3m = 15; s.wa3w = 15; s.ra1e = 15;
    cycle(s);
    check("fwd_PC_A", int'(bus.ForwardAE), 0);

    // Load-use stall for one cycle.
    s = idle(); s.cnt_clr = 1;
    cycle(s);
    cycle(ldr_use());
    check("ldr_StallF", int'(bus.StallF), 1);
    check("ldr_StallD", int'(bus.StallD), 1);
    check("ldr_FlushE", int'(bus.FlushE), 1);
    check("ldr_FlushD", int'(bus.FlushD), 0);
    cycle(idle());
    check("ldr_stall_cnt", int'(bus.stall_cnt), 1);
    check("ldr_flush_cnt", int'(bus.flush_cnt), 1);

    // PC write that commits.
    cycle(idle()); cycle(idle());
    s = idle(); s.pcsrc_d = 1;
    cycle(s);
    check("pc0_StallF", int'(bus.StallF), 1);
    check("pc0_FlushD", int'(bus.FlushD), 1);
    s = idle(); s.pcsrc_e = 1;
    cycle(s);
    check("pc1_StallF", int'(bus.StallF), 1);
    check("pc1_FlushD", int'(bus.FlushD), 1);
    cycle(idle());
    check("pc2_StallF", int'(bus.StallF), 1);
    check("pc2_PCSrcW", int'(bus.PCSrcW), 0);
    cycle(idle());
    check("pc3_StallF", int'(bus.StallF), 0);
    check("pc3_FlushD", int'(bus.FlushD), 1);
    check("pc3_PCSrcW", int'(bus.PCSrcW), 1);
    cycle(idle());
    check("pc4_FlushD", int'(bus.FlushD), 0);
    check("pc4_PCSrcW", int'(bus.PCSrcW), 0);

    // PC write whose condition fails in E.
    s = idle(); s.pcsrc_d = 1;
    cycle(s);
    cycle(idle());
    check("pcf1_StallF", int'(bus.StallF), 1);
    for (int i = 2; i < 5; i++) begin
      cycle(idle());
      check("pcf_StallF", int'(bus.StallF), 0);
      check("pcf_PCSrcW", int'(bus.PCSrcW), 0);
    end

    // Taken branch versus a wrong-path PC write in decode.
    s = idle(); s.br_e = 1; s.pcsrc_d = 1;
    cycle(s);
    check("br_StallF", int'(bus.StallF), 0);
    check("br_FlushD", int'(bus.FlushD), 1);
    check("br_FlushE", int'(bus.FlushE), 1);
    cycle(idle());
    check("br_next_StallF", int'(bus.StallF), 0);
    check("br_next_FlushD", int'(bus.FlushD), 0);

    // Counter saturation and clear priority.
    s = idle(); s.cnt_clr = 1;
    cycle(s);
    repeat (20) cycle(ldr_use());
    check("sat_stall_cnt", int'(bus.stall_cnt), CNT_MAX);
    check("sat_flush_cnt", int'(bus.flush_cnt), CNT_MAX);
    s = ldr_use(); s.cnt_clr = 1;
    cycle(s);
    check("clr_StallF", int'(bus.StallF), 1);
    cycle(ldr_use());
    check("clr_stall_cnt", int'(bus.stall_cnt), 0);
    cycle(idle());
    check("clr_inc_stall_cnt", int'(bus.stall_cnt), 1);

    // Reset in the middle of a PC write discards it.
    s = idle(); s.pcsrc_d = 1;
    cycle(s);
    s = idle(); s.pcsrc_e = 1;
    cycle(s);
    s = idle(); s.reset = 1;
    cycle(s);
    for (int i = 0; i < 3; i++) begin
      cycle(idle());
      check("rstpc_PCSrcW", int'(bus.PCSrcW), 0);
      check("rstpc_StallF", int'(bus.StallF), 0);
    end
    check("rstpc_stall_cnt", int'(bus.stall_cnt), 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      s = '0;
      s.reset   = ($urandom_range(0, 63) == 0);
      s.cnt_clr = ($urandom_range(0, 31) == 0);
      s.pcsrc_d = ($urandom_range(0, 5) == 0);
      s.pcsrc_e = ($urandom_range(0, 3) == 0);
      s.br_e    = ($urandom_range(0, 7) == 0);
      s.rw_e    = 1'($urandom_range(0, 1));
      s.m2r_e   = ($urandom_range(0, 2) == 0);
      s.rw_m    = 1'($urandom_range(0, 1));
      s.rw_w    = 1'($urandom_range(0, 1));
      s.ra1d = rand_reg(); s.ra2d = rand_reg();
      s.ra1e = rand_reg(); s.ra2e = rand_reg();
      s.wa3e = rand_reg(); s.wa3m = rand_reg(); s.wa3w = rand_reg();
      cycle(s);
    end

    cycle(idle());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
